// File: rtl/rsa_pkg.sv
// Shared types for the Montgomery exponentiation sequencer: FSM state encoding and operand-mux codes.
package rsa_pkg;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_PRE_MAP    = 4'd1,
        S_MAP        = 4'd2,
        S_POST_MAP   = 4'd3,
        S_PRE_MMM    = 4'd4,
        S_MMM        = 4'd5,
        S_POST_MMM   = 4'd6,
        S_PRE_REMAP  = 4'd7,
        S_REMAP      = 4'd8,
        S_POST_REMAP = 4'd9,
        S_DONE       = 4'd10
    } rsa_seq_state_t;

    localparam logic [1:0] SEL1_MAP   = 2'b00;
    localparam logic [1:0] SEL1_RND   = 2'b01;
    localparam logic [1:0] SEL1_REMAP = 2'b10;

endpackage

// File: rtl/rsa_step_counter.sv
// Up-counter with synchronous clear and increment, gated by the block clock enable.
module rsa_step_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Clear beats increment so a POST state can zero the counter unconditionally.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_cnt <= '0;
        end else if (ena) begin
            if (clear)
                r_cnt <= '0;
            else if (inc)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/rsa_expo_sequencer.sv
// Control sequencer for Montgomery modular exponentiation: map-in, one MMM round per
// exponent bit (LSB first), remap-out, with start/busy/eoc handshake and abort.
module rsa_expo_sequencer
    import rsa_pkg::*;
#(
    parameter  int WIDTH      = 8,
    parameter  int EXP_WIDTH  = WIDTH + 2,
    parameter  int MMM_CYCLES = WIDTH + 2,
    localparam int LEN_W      = $clog2(EXP_WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 ena,
    input  logic                 start,
    input  logic                 abort,
    input  logic [EXP_WIDTH-1:0] expE,
    input  logic [LEN_W-1:0]     exp_len,
    output logic                 rst_mmm,
    output logic                 ld_a,
    output logic                 ld_r,
    output logic                 lock1,
    output logic                 lock2,
    output logic [1:0]           sel1,
    output logic                 sel2,
    output logic                 busy,
    output logic                 eoc
);

    localparam int                STEP_W    = $clog2(MMM_CYCLES + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MMM_CYCLES);
    localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(EXP_WIDTH);

    if (WIDTH < 1 || EXP_WIDTH < 1 || MMM_CYCLES < 1) begin : g_bad_param
        $error("rsa_expo_sequencer: WIDTH, EXP_WIDTH and MMM_CYCLES must be positive");
    end

    rsa_seq_state_t        r_state;
    rsa_seq_state_t        w_next;
    logic [EXP_WIDTH-1:0]  r_exp;
    logic [LEN_W-1:0]      r_len;
    logic [STEP_W-1:0]     w_steps;
    logic [LEN_W-1:0]      w_rounds;
    logic                  w_accept;
    logic                  w_step_last;
    logic [LEN_W-1:0]      w_len_sat;

    assign w_accept    = start && !abort && (r_state == S_IDLE || r_state == S_DONE);
    assign w_step_last = (w_steps == STEP_LAST);
    assign w_len_sat   = (exp_len > LEN_MAX) ? LEN_MAX : exp_len;

    rsa_step_counter #(.CNT_W(STEP_W)) u_steps (
        .clk   (clk),
        .rstb  (rstb),
        .ena   (ena),
        .clear (abort || r_state == S_POST_MAP || r_state == S_POST_MMM
                      || r_state == S_POST_REMAP),
        .inc   (r_state == S_MAP || r_state == S_MMM || r_state == S_REMAP),
        .cnt   (w_steps)
    );

    rsa_step_counter #(.CNT_W(LEN_W)) u_rounds (
        .clk   (clk),
        .rstb  (rstb),
        .ena   (ena),
        .clear (abort || r_state == S_PRE_REMAP),
        .inc   (r_state == S_POST_MMM),
        .cnt   (w_rounds)
    );

    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_state <= S_IDLE;
            r_exp   <= '0;
            r_len   <= '0;
        end else if (ena) begin
            r_state <= w_next;
            if (abort) begin
                r_exp <= '0;
                r_len <= '0;
            end else if (w_accept) begin
                r_exp <= expE;
                r_len <= w_len_sat;
            end else if (r_state == S_POST_MMM) begin
                r_exp <= r_exp >> 1;
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        rst_mmm = 1'b0;
        ld_a    = 1'b0;
        ld_r    = 1'b0;
        lock1   = 1'b0;
        lock2   = 1'b0;
        sel1    = SEL1_MAP;
        sel2    = 1'b0;
        busy    = 1'b0;
        eoc     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_PRE_MAP;
            end
            S_PRE_MAP, S_MAP: begin
                {rst_mmm, ld_a, lock1, lock2, busy} = 5'b11111;
                if (r_state == S_PRE_MAP) w_next = S_MAP;
                else if (w_step_last)     w_next = S_POST_MAP;
            end
            S_POST_MAP: begin
                {rst_mmm, ld_r, lock1, lock2, busy} = 5'b11111;
                w_next = (r_len == '0) ? S_PRE_REMAP : S_PRE_MMM;
            end
            S_PRE_MMM, S_MMM, S_POST_MMM: begin
                // Only the R-side update is gated by the current exponent bit.
                {rst_mmm, lock2, sel2, busy} = 4'b1111;
                lock1 = r_exp[0];
                sel1  = SEL1_RND;
                ld_a  = (r_state == S_PRE_MMM);
                ld_r  = (r_state == S_POST_MMM);
                if (r_state == S_PRE_MMM)
                    w_next = S_MMM;
                else if (r_state == S_MMM && w_step_last)
                    w_next = S_POST_MMM;
                else if (r_state == S_POST_MMM)
                    w_next = (w_rounds == r_len - LEN_W'(1)) ? S_PRE_REMAP : S_PRE_MMM;
            end
            S_PRE_REMAP, S_REMAP, S_POST_REMAP: begin
                {rst_mmm, lock1, sel2, busy} = 4'b1111;
                sel1 = SEL1_REMAP;
                ld_a = (r_state == S_PRE_REMAP);
                ld_r = (r_state == S_POST_REMAP);
                if (r_state == S_PRE_REMAP)
                    w_next = S_REMAP;
                else if (r_state == S_REMAP && w_step_last)
                    w_next = S_POST_REMAP;
                else if (r_state == S_POST_REMAP)
                    w_next = S_DONE;
            end
            S_DONE: begin
                {rst_mmm, lock1, sel2, eoc} = 4'b1111;
                sel1 = SEL1_REMAP;
                if (w_accept) w_next = S_PRE_MAP;
            end
            default: w_next = S_IDLE;
        endcase
        if (abort) w_next = S_IDLE;
    end

endmodule

// File: tb/tb_rsa_expo_sequencer.sv
// Bench for rsa_expo_sequencer: phase-level trace model compared every cycle, plus directed latency/sequence checks.
module tb_rsa_expo_sequencer;
    localparam int W  = 8;
    localparam int EW = 10;
    localparam int MC = 10;
    localparam int LW = 4;

    logic clk = 1'b0, rstb = 1'b0, ena = 1'b0, start = 1'b0, abort = 1'b0;
    logic [EW-1:0] expE = '0;
    logic [LW-1:0] exp_len = '0;
    logic rst_mmm, ld_a, ld_r, lock1, lock2, sel2, busy, eoc;
    logic [1:0] sel1;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    logic [9:0] exp_cur = '0;
    logic [9:0] q[$];

    always #5 clk = ~clk;

    rsa_expo_sequencer #(.WIDTH(W), .EXP_WIDTH(EW), .MMM_CYCLES(MC)) dut (
        .clk(clk), .rstb(rstb), .ena(ena), .start(start), .abort(abort),
        .expE(expE), .exp_len(exp_len),
        .rst_mmm(rst_mmm), .ld_a(ld_a), .ld_r(ld_r), .lock1(lock1), .lock2(lock2),
        .sel1(sel1), .sel2(sel2), .busy(busy), .eoc(eoc)
    );

    wire [9:0] dv = {rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2, busy, eoc};

    function automatic logic [9:0] ov(input logic rm, la, lr, l1, l2,
                                      input logic [1:0] s1, input logic s2, bz, eo);
        return {rm, la, lr, l1, l2, s1, s2, bz, eo};
    endfunction

    // One phase = a set-up cycle, MC+1 working cycles, a write-back cycle.
    task automatic push_phase(input logic [9:0] pre, body, post);
        q.push_back(pre);
        repeat (MC + 1) q.push_back(body);
        q.push_back(post);
    endtask

    task automatic build(input logic [EW-1:0] e, input int len);
        int l;
        l = (len > EW) ? EW : len;
        push_phase(ov(1'b1,1'b1,1'b0,1'b1,1'b1,2'b00,1'b0,1'b1,1'b0),
                   ov(1'b1,1'b1,1'b0,1'b1,1'b1,2'b00,1'b0,1'b1,1'b0),
                   ov(1'b1,1'b0,1'b1,1'b1,1'b1,2'b00,1'b0,1'b1,1'b0));
        for (int r = 0; r < l; r++)
            push_phase(ov(1'b1,1'b1,1'b0,e[r],1'b1,2'b01,1'b1,1'b1,1'b0),
                       ov(1'b1,1'b0,1'b0,e[r],1'b1,2'b01,1'b1,1'b1,1'b0),
                       ov(1'b1,1'b0,1'b1,e[r],1'b1,2'b01,1'b1,1'b1,1'b0));
        push_phase(ov(1'b1,1'b1,1'b0,1'b1,1'b0,2'b10,1'b1,1'b1,1'b0),
                   ov(1'b1,1'b0,1'b0,1'b1,1'b0,2'b10,1'b1,1'b1,1'b0),
                   ov(1'b1,1'b0,1'b1,1'b1,1'b0,2'b10,1'b1,1'b1,1'b0));
        q.push_back(ov(1'b1,1'b0,1'b0,1'b1,1'b0,2'b10,1'b1,1'b0,1'b1));
    endtask

    // Model: expected output word advances one trace entry per enabled edge.
    initial forever begin
        @(posedge clk);
        if (!rstb) begin
            q.delete();
            exp_cur = '0;
        end else if (ena) begin
            if (abort) begin
                q.delete();
                exp_cur = '0;
            end else if (start && !exp_cur[1]) begin
                q.delete();
                build(expE, int'(exp_len));
                exp_cur = q.pop_front();
            end else if (q.size() > 0) begin
                exp_cur = q.pop_front();
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            n_cmp++;
            if (dv !== exp_cur) begin
                n_err++;
                $display("FAIL outputs t=%0t dut=%b expected=%b", $time, dv, exp_cur);
            end
        end
    end

    task automatic check(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic run_op(input logic [EW-1:0] e, input logic [LW-1:0] len,
                          input int frz_at, input int frz_n, input int bs_at,
                          output int cyc, output logic [15:0] l1v, output int nl1,
                          output bit saw_rnd);
        expE = e; exp_len = len; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        expE = EW'($urandom); exp_len = LW'($urandom);
        check("busy_after_start", int'(busy), 1);
        check("first_sel1_map", int'(sel1), 0);
        cyc = 0; l1v = '0; nl1 = 0; saw_rnd = 1'b0;
        while (!eoc && cyc < 2000) begin
            if (cyc == frz_at) ena = 1'b0;
            if (cyc == frz_at + frz_n) ena = 1'b1;
            start = (cyc == bs_at);
            @(negedge clk);
            cyc++;
            if (sel1 == 2'b01) saw_rnd = 1'b1;
            if (busy && ld_a && sel1 == 2'b01 && nl1 < 16) begin
                l1v[nl1] = lock1;
                nl1++;
            end
        end
        start = 1'b0; ena = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, nl1, n;
        logic [15:0] l1v;
        bit saw;
        logic [EW-1:0] e;

        rstb = 1'b0; ena = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset_outputs", int'(dv), 0);
        rstb = 1'b1;
        @(negedge clk);

        // Reference exponent: lock1 order follows LSB-first bits.
        run_op(10'b1010000011, 4'd10, -1, 0, -1, cyc, l1v, nl1, saw);
        check("lat_len10", cyc, 156);
        check("lock1_rounds", int'(l1v[9:0]), int'(10'b1010000011));
        check("rounds_len10", nl1, 10);

        run_op(EW'($urandom), 4'd0, -1, 0, -1, cyc, l1v, nl1, saw);
        check("lat_len0", cyc, 26);
        check("len0_no_round", int'(saw), 0);
        check("len0_done_sel1", int'(sel1), 2);

        e = EW'($urandom);
        run_op(e, 4'd15, -1, 0, -1, cyc, l1v, nl1, saw);
        check("lat_len15_sat", cyc, 156);
        check("lock1_len15", int'(l1v[9:0]), int'(e));

        // Abort inside the MMM body of round 3.
        expE = EW'($urandom); exp_len = 4'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (55) @(negedge clk);
        check("pre_abort_in_mmm", int'({sel1, ld_a}), int'(3'b010));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_outputs", int'(dv), 0);
        repeat (10) @(negedge clk);
        check("abort_no_eoc", int'(eoc), 0);
        e = EW'($urandom);
        run_op(e, 4'd10, -1, 0, -1, cyc, l1v, nl1, saw);
        check("lat_after_abort", cyc, 156);
        check("lock1_after_abort", int'(l1v[9:0]), int'(e));

        // Freeze mid-MAP for 20 cycles, plus a start pulse while busy.
        run_op(EW'($urandom), 4'd10, 5, 20, 30, cyc, l1v, nl1, saw);
        check("lat_freeze20", cyc, 176);

        // Reset for one cycle during REMAP.
        expE = EW'($urandom); exp_len = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (44) @(negedge clk);
        check("pre_reset_in_remap", int'({sel1, ld_a}), int'(3'b100));
        rstb = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        check("reset_remap_outputs", int'(dv), 0);
        repeat (40) @(negedge clk);
        check("reset_no_eoc", int'(eoc), 0);

        // start and abort together while DONE.
        run_op(EW'($urandom), 4'd3, -1, 0, -1, cyc, l1v, nl1, saw);
        check("lat_len3", cyc, 65);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("done_abort_outputs", int'(dv), 0);

        // Randomized operations with enable gaps, stray starts and rare aborts.
        for (int it = 0; it < 30; it++) begin
            expE = EW'($urandom); exp_len = LW'($urandom_range(0, 15)); start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n = 0;
            while (exp_cur[1] && n < 800) begin
                ena   = ($urandom_range(0, 7) != 0);
                start = ($urandom_range(0, 15) == 0);
                abort = ($urandom_range(0, 199) == 0);
                expE  = EW'($urandom); exp_len = LW'($urandom);
                @(negedge clk);
                n++;
            end
            ena = 1'b1; start = 1'b0; abort = 1'b0;
            if (n >= 800) begin
                n_cmp++; n_err++;
                $display("FAIL rand_timeout iteration=%0d cycles=%0d", it, n);
            end
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
